// File: rtl/cpu_out_uart_if.sv
// cpu_out_uart_if: write-back capture inputs (CPU_out, Sample) and UART status outputs (Tx, Busy, Overflow, Count)
interface cpu_out_uart_if #(
  parameter int FIFO_DEPTH = 8
);
  logic [31:0]                 CPU_out;
  logic                        Sample;
  logic                        Tx;
  logic                        Busy;
  logic                        Overflow;
  logic [$clog2(FIFO_DEPTH):0] Count;
  modport master (output CPU_out, Sample, input Tx, Busy, Overflow, Count);
  modport slave (input CPU_out, Sample, output Tx, Busy, Overflow, Count);
endinterface

// File: rtl/cpu_out_uart.sv
// cpu_out_uart: queue strobed CPU write-back words, send each as 8 hex chars + CR LF over 8N1 UART (ports Clk, Reset, bus: CPU_out/Sample in, Tx/Busy/Overflow/Count out)
module cpu_out_uart #(
  parameter int CLK_DIV     = 868,
  parameter int FIFO_DEPTH  = 8,
  parameter int CHANGE_ONLY = 1
)(
  input logic            Clk,
  input logic            Reset,
  cpu_out_uart_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLK_DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   last, word, sh;
  logic          have_last, overflow, tx, busy;
  logic          tick, last_char, pop, push_req, push_ok;
  logic [TW-1:0] tmr;
  logic [2:0]    bit_idx;
  logic [3:0]    char_idx, nib;
  logic [7:0]    ch;
  always_comb begin
    tick      = tmr == TW'(CLK_DIV - 1);
    last_char = char_idx == 4'd9;
    // pop from idle, or straight into the next word when the final stop bit ends
    pop       = count != '0 && (state == IDLE || (state == STOP && tick && last_char));
    push_req  = bus.Sample && (CHANGE_ONLY == 0 || !have_last || bus.CPU_out != last);
    push_ok   = push_req && (count != (AW+1)'(FIFO_DEPTH) || pop);
    sh        = word << {char_idx[2:0], 2'b00};
    nib       = sh[31:28];
    ch        = char_idx == 4'd8 ? 8'h0D :
                last_char        ? 8'h0A :
                nib < 4'd10      ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
  end
  always_ff @(posedge Clk)
    if (push_ok) mem[wr_ptr] <= bus.CPU_out;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      have_last <= 1'b0;
      last      <= '0;
    end else begin
      if (push_req) begin
        last      <= bus.CPU_out;
        have_last <= 1'b1;
      end
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (push_req && !push_ok) overflow <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end
  // Tx is registered from the current state, so the line lags the FSM by one cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tmr      <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      word     <= '0;
    end else begin
      tx  <= state == START ? 1'b0 : state == DATA ? ch[bit_idx] : 1'b1;
      tmr <= (state == IDLE || tick) ? '0 : tmr + 1'b1;
      case (state)
        IDLE:
          if (pop) begin
            word     <= mem[rd_ptr];
            char_idx <= '0;
            busy     <= 1'b1;
            state    <= START;
          end
        START:
          if (tick) begin
            bit_idx <= '0;
            state   <= DATA;
          end
        DATA:
          if (tick) begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        default:
          if (tick) begin
            if (!last_char) begin
              char_idx <= char_idx + 1'b1;
              state    <= START;
            end else if (pop) begin
              word     <= mem[rd_ptr];
              char_idx <= '0;
              state    <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
      endcase
    end
  end
  assign bus.Tx       = tx;
  assign bus.Busy     = busy;
  assign bus.Overflow = overflow;
  assign bus.Count    = count;
endmodule
